// File: rtl/ibex_pkg.sv
// Shared Ibex definitions used by the interrupt arbiter: exception cause codes,
// the pending-bit payload and the per-source edge latch state.
package ibex_pkg;

    localparam int unsigned EXC_CAUSE_W = 6;
    localparam int unsigned NUM_FAST    = 15;
    localparam int unsigned FAST_ID_W   = 4;

    typedef logic [EXC_CAUSE_W-1:0] exc_cause_t;

    localparam exc_cause_t EXC_CAUSE_IRQ_SOFTWARE_M = 6'h23;
    localparam exc_cause_t EXC_CAUSE_IRQ_TIMER_M    = 6'h27;
    localparam exc_cause_t EXC_CAUSE_IRQ_EXTERNAL_M = 6'h2B;
    localparam exc_cause_t EXC_CAUSE_IRQ_NM         = 6'h3F;

    // Edge-latched source: IDLE until an edge is seen, PEND until acknowledged.
    typedef enum logic {
        IRQ_IDLE = 1'b0,
        IRQ_PEND = 1'b1
    } irq_src_state_e;

    // Masked pending bits presented to the controller.
    typedef struct packed {
        logic                msip;
        logic                mtip;
        logic                meip;
        logic [NUM_FAST-1:0] mfip;
    } irq_pend_t;

    // Cause code the controller reports when it takes fast interrupt `id`.
    function automatic exc_cause_t exc_cause_irq_fast(input logic [FAST_ID_W-1:0] id);
        return {2'b11, id};
    endfunction

    // Highest set fast line wins; 0 when nothing is pending.
    function automatic logic [FAST_ID_W-1:0] fast_irq_id(input logic [NUM_FAST-1:0] pend);
        logic [FAST_ID_W-1:0] id;
        id = '0;
        for (int unsigned i = 0; i < NUM_FAST; i++) begin
            if (pend[i]) begin
                id = FAST_ID_W'(i);
            end
        end
        return id;
    endfunction

endpackage

// File: rtl/ibex_irq_sync.sv
// Single-bit multi-flop synchroniser for a raw interrupt line, synchronous active-low reset.
module ibex_irq_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/ibex_irq_arbiter.sv
// Interrupt source side of the controller irq interface: synchronises, latches and masks
// platform interrupts. Optional IBEX_IRQ_ACK_CNT_EN adds a saturating ack counter.
module ibex_irq_arbiter
    import ibex_pkg::*;
#(
    parameter int unsigned   SYNC_STAGES    = 2,
    parameter logic [14:0]   FAST_EDGE_MASK = 15'h0000
) (
    input  logic        CK,
    input  logic        rst_ni,
    input  logic        irq_software_i,
    input  logic        irq_timer_i,
    input  logic        irq_external_i,
    input  logic [14:0] irq_fast_i,
    input  logic        irq_nm_i,
    input  logic        mie_msie_i,
    input  logic        mie_mtie_i,
    input  logic        mie_meie_i,
    input  logic [14:0] mie_mfie_i,
    input  logic        irq_ack_i,
    input  logic [5:0]  irq_ack_cause_i,
    output logic        csr_msip_o,
    output logic        csr_mtip_o,
    output logic        csr_meip_o,
    output logic [14:0] csr_mfip_o,
    output logic        irq_pending_o,
    output logic        irq_nm_o,
    output logic [3:0]  irq_fast_id_o,
    output logic [15:0] irq_ack_cnt_o
);

    localparam int unsigned NUM_RAW   = NUM_FAST + 4;
    localparam int unsigned NUM_SRC   = NUM_FAST + 1;
    localparam int unsigned NMI_IDX   = NUM_FAST;
    localparam int unsigned ACK_CNT_W = 16;

    // Fast lines plus the NMI, which is always edge-latched.
    localparam logic [NUM_SRC-1:0] SRC_EDGE_MASK = {1'b1, FAST_EDGE_MASK};

    logic [NUM_RAW-1:0] raw_irq;
    logic [NUM_RAW-1:0] sync_irq;
    logic [NUM_SRC-1:0] src_line;
    logic [NUM_SRC-1:0] src_pend;

    irq_pend_t            pend_c;
    logic                 pending_c;
    irq_pend_t            pend_q;
    logic                 pending_q;
    logic                 nm_q;
    logic [FAST_ID_W-1:0] fast_id_q;

    assign raw_irq = {irq_nm_i, irq_fast_i, irq_external_i, irq_timer_i, irq_software_i};

    for (genvar g = 0; g < NUM_RAW; g++) begin : gen_sync
        ibex_irq_sync #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .clk_i (CK),
            .rst_ni(rst_ni),
            .d_i   (raw_irq[g]),
            .q_o   (sync_irq[g])
        );
    end

    assign src_line = sync_irq[NUM_RAW-1:3];

    // Per source: level lines pass straight through, edge lines get an IDLE/PEND latch.
    for (genvar g = 0; g < NUM_SRC; g++) begin : gen_src
        if (SRC_EDGE_MASK[g]) begin : gen_edge
            localparam exc_cause_t ACK_CAUSE = (g == NMI_IDX) ? EXC_CAUSE_IRQ_NM
                                                              : exc_cause_irq_fast(FAST_ID_W'(g));

            irq_src_state_e state_q;
            irq_src_state_e state_d;
            logic           line_d_q;
            logic           rise;
            logic           ack_hit;

            assign rise    = src_line[g] & ~line_d_q;
            assign ack_hit = irq_ack_i && (irq_ack_cause_i == ACK_CAUSE);

            always_ff @(posedge CK) begin
                if (!rst_ni) begin
                    state_q  <= IRQ_IDLE;
                    line_d_q <= 1'b0;
                end else begin
                    state_q  <= state_d;
                    line_d_q <= src_line[g];
                end
            end

            // A fresh edge in the ack cycle keeps the source pending.
            always_comb begin
                state_d = state_q;
                unique case (state_q)
                    IRQ_IDLE: if (rise)             state_d = IRQ_PEND;
                    IRQ_PEND: if (ack_hit && !rise) state_d = IRQ_IDLE;
                endcase
            end

            assign src_pend[g] = (state_q == IRQ_PEND);
        end else begin : gen_level
            assign src_pend[g] = src_line[g];
        end
    end

    always_comb begin
        pend_c      = '0;
        pend_c.msip = sync_irq[0] & mie_msie_i;
        pend_c.mtip = sync_irq[1] & mie_mtie_i;
        pend_c.meip = sync_irq[2] & mie_meie_i;
        pend_c.mfip = src_pend[NUM_FAST-1:0] & mie_mfie_i;
        pending_c   = pend_c.msip | pend_c.mtip | pend_c.meip | (|pend_c.mfip);
    end

    always_ff @(posedge CK) begin
        if (!rst_ni) begin
            pend_q    <= '0;
            pending_q <= 1'b0;
            nm_q      <= 1'b0;
            fast_id_q <= '0;
        end else begin
            pend_q    <= pend_c;
            pending_q <= pending_c;
            nm_q      <= src_pend[NMI_IDX];
            fast_id_q <= fast_irq_id(pend_c.mfip);
        end
    end

    assign csr_msip_o    = pend_q.msip;
    assign csr_mtip_o    = pend_q.mtip;
    assign csr_meip_o    = pend_q.meip;
    assign csr_mfip_o    = pend_q.mfip;
    assign irq_pending_o = pending_q;
    assign irq_nm_o      = nm_q;
    assign irq_fast_id_o = fast_id_q;

`ifdef IBEX_IRQ_ACK_CNT_EN
    logic [ACK_CNT_W-1:0] ack_cnt_q;

    // Saturating count of ack cycles.
    always_ff @(posedge CK) begin
        if (!rst_ni) begin
            ack_cnt_q <= '0;
        end else if (irq_ack_i && (ack_cnt_q != {ACK_CNT_W{1'b1}})) begin
            ack_cnt_q <= ack_cnt_q + ACK_CNT_W'(1);
        end
    end

    assign irq_ack_cnt_o = ack_cnt_q;
`else
    assign irq_ack_cnt_o = ACK_CNT_W'(0);
`endif

endmodule

// File: tb/tb_ibex_irq_arbiter.sv
// Self-checking bench for ibex_irq_arbiter: vector table with a scoreboard queue plus
// directed sequences for edge latching, ack handling, reset and the optional ack counter.
module tb_ibex_irq_arbiter;

    localparam int unsigned S = 2;
    localparam logic [5:0] C_NM   = 6'h3F;
    localparam logic [5:0] C_EXT  = 6'h2B;
    localparam logic [5:0] C_F3   = 6'h33;
    localparam logic [5:0] C_F4   = 6'h34;

    logic        CK;
    logic        rst_ni;
    logic        irq_software_i, irq_timer_i, irq_external_i, irq_nm_i;
    logic [14:0] irq_fast_i;
    logic        mie_msie_i, mie_mtie_i, mie_meie_i;
    logic [14:0] mie_mfie_i;
    logic        irq_ack_i;
    logic [5:0]  irq_ack_cause_i;
    logic        csr_msip_o, csr_mtip_o, csr_meip_o;
    logic [14:0] csr_mfip_o;
    logic        irq_pending_o, irq_nm_o;
    logic [3:0]  irq_fast_id_o;
    logic [15:0] irq_ack_cnt_o;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        sw, tim, ext;
        logic [14:0] fast;
        logic        msie, mtie, meie;
        logic [14:0] mfie;
        logic        msip, mtip, meip;
        logic [14:0] mfip;
        logic        pend;
        logic [3:0]  id;
    } vec_t;

    typedef struct packed {
        logic        msip, mtip, meip;
        logic [14:0] mfip;
        logic        pend;
        logic [3:0]  id;
    } exp_t;

    vec_t vecs[10];
    exp_t sb[$];

    ibex_irq_arbiter #(
        .SYNC_STAGES   (S),
        .FAST_EDGE_MASK(15'h0008)
    ) dut (
        .CK             (CK),
        .rst_ni         (rst_ni),
        .irq_software_i (irq_software_i),
        .irq_timer_i    (irq_timer_i),
        .irq_external_i (irq_external_i),
        .irq_fast_i     (irq_fast_i),
        .irq_nm_i       (irq_nm_i),
        .mie_msie_i     (mie_msie_i),
        .mie_mtie_i     (mie_mtie_i),
        .mie_meie_i     (mie_meie_i),
        .mie_mfie_i     (mie_mfie_i),
        .irq_ack_i      (irq_ack_i),
        .irq_ack_cause_i(irq_ack_cause_i),
        .csr_msip_o     (csr_msip_o),
        .csr_mtip_o     (csr_mtip_o),
        .csr_meip_o     (csr_meip_o),
        .csr_mfip_o     (csr_mfip_o),
        .irq_pending_o  (irq_pending_o),
        .irq_nm_o       (irq_nm_o),
        .irq_fast_id_o  (irq_fast_id_o),
        .irq_ack_cnt_o  (irq_ack_cnt_o)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    task automatic tick(input int n);
        repeat (n) @(negedge CK);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic ack(input logic [5:0] cause);
        irq_ack_i       = 1'b1;
        irq_ack_cause_i = cause;
        tick(1);
        irq_ack_i       = 1'b0;
        irq_ack_cause_i = 6'h00;
    endtask

    task automatic raw_all(input logic v);
        irq_software_i = v;
        irq_timer_i    = v;
        irq_external_i = v;
        irq_fast_i     = {15{v}};
        irq_nm_i       = v;
    endtask

    initial begin
        exp_t e;

        //          sw    tim   ext   fast      msie  mtie  meie  mfie      msip  mtip  meip  mfip      pend  id
        vecs[0] = '{1'b0, 1'b0, 1'b1, 15'h0000, 1'b0, 1'b0, 1'b0, 15'h0000, 1'b0, 1'b0, 1'b0, 15'h0000, 1'b0, 4'd0};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 15'h0000, 1'b0, 1'b0, 1'b1, 15'h0000, 1'b0, 1'b0, 1'b1, 15'h0000, 1'b1, 4'd0};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 15'h0000, 1'b1, 1'b0, 1'b0, 15'h0000, 1'b1, 1'b0, 1'b0, 15'h0000, 1'b1, 4'd0};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 15'h0000, 1'b0, 1'b1, 1'b0, 15'h0000, 1'b0, 1'b1, 1'b0, 15'h0000, 1'b1, 4'd0};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 15'h4004, 1'b0, 1'b0, 1'b0, 15'h7FFF, 1'b0, 1'b0, 1'b0, 15'h4004, 1'b1, 4'd14};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 15'h0004, 1'b0, 1'b0, 1'b0, 15'h7FFF, 1'b0, 1'b0, 1'b0, 15'h0004, 1'b1, 4'd2};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 15'h4004, 1'b0, 1'b0, 1'b0, 15'h0004, 1'b0, 1'b0, 1'b0, 15'h0004, 1'b1, 4'd2};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 15'h0001, 1'b0, 1'b0, 1'b0, 15'h0001, 1'b0, 1'b0, 1'b0, 15'h0001, 1'b1, 4'd0};
        vecs[8] = '{1'b1, 1'b1, 1'b1, 15'h7FF7, 1'b0, 1'b0, 1'b0, 15'h0000, 1'b0, 1'b0, 1'b0, 15'h0000, 1'b0, 4'd0};
        vecs[9] = '{1'b1, 1'b1, 1'b1, 15'h7FF7, 1'b1, 1'b1, 1'b1, 15'h7FFF, 1'b1, 1'b1, 1'b1, 15'h7FF7, 1'b1, 4'd14};

        // Reset with every raw line high and every enable set
        rst_ni          = 1'b0;
        raw_all(1'b1);
        mie_msie_i      = 1'b1;
        mie_mtie_i      = 1'b1;
        mie_meie_i      = 1'b1;
        mie_mfie_i      = 15'h7FFF;
        irq_ack_i       = 1'b0;
        irq_ack_cause_i = 6'h00;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check($sformatf("rst_pending_%0d", i), 32'(irq_pending_o), 32'd0);
            check($sformatf("rst_meip_%0d", i),    32'(csr_meip_o),    32'd0);
            check($sformatf("rst_mfip_%0d", i),    32'(csr_mfip_o),    32'd0);
            check($sformatf("rst_nm_%0d", i),      32'(irq_nm_o),      32'd0);
            check($sformatf("rst_id_%0d", i),      32'(irq_fast_id_o), 32'd0);
        end
        rst_ni = 1'b1;
        tick(S);
        check("rel_meip_early", 32'(csr_meip_o), 32'd0);
        tick(1);
        check("rel_meip",    32'(csr_meip_o),    32'd1);
        check("rel_pending", 32'(irq_pending_o), 32'd1);
        check("rel_mfip",    32'(csr_mfip_o),    32'h7FF7);
        check("rel_id",      32'(irq_fast_id_o), 32'd14);
        check("rel_nm_early", 32'(irq_nm_o),     32'd0);
        tick(1);
        check("rel_nm",        32'(irq_nm_o),   32'd1);
        check("rel_mfip_edge", 32'(csr_mfip_o), 32'h7FFF);

        // Drop all lines and clear both latched sources
        raw_all(1'b0);
        ack(C_NM);
        ack(C_F3);
        tick(S + 3);
        check("clr_nm",      32'(irq_nm_o),      32'd0);
        check("clr_mfip",    32'(csr_mfip_o),    32'd0);
        check("clr_pending", 32'(irq_pending_o), 32'd0);

        // Level/mask/priority vector table through the scoreboard
        foreach (vecs[i]) begin
            irq_software_i = vecs[i].sw;
            irq_timer_i    = vecs[i].tim;
            irq_external_i = vecs[i].ext;
            irq_fast_i     = vecs[i].fast;
            mie_msie_i     = vecs[i].msie;
            mie_mtie_i     = vecs[i].mtie;
            mie_meie_i     = vecs[i].meie;
            mie_mfie_i     = vecs[i].mfie;
            sb.push_back('{vecs[i].msip, vecs[i].mtip, vecs[i].meip, vecs[i].mfip,
                           vecs[i].pend, vecs[i].id});
            tick(S + 2);
            e = sb.pop_front();
            check($sformatf("vec%0d_msip", i), 32'(csr_msip_o),    32'(e.msip));
            check($sformatf("vec%0d_mtip", i), 32'(csr_mtip_o),    32'(e.mtip));
            check($sformatf("vec%0d_meip", i), 32'(csr_meip_o),    32'(e.meip));
            check($sformatf("vec%0d_mfip", i), 32'(csr_mfip_o),    32'(e.mfip));
            check($sformatf("vec%0d_pend", i), 32'(irq_pending_o), 32'(e.pend));
            check($sformatf("vec%0d_id", i),   32'(irq_fast_id_o), 32'(e.id));
        end

        // Enable change is visible one edge later
        raw_all(1'b0);
        mie_msie_i     = 1'b0;
        mie_mtie_i     = 1'b0;
        mie_meie_i     = 1'b0;
        mie_mfie_i     = 15'h0000;
        irq_external_i = 1'b1;
        tick(S + 2);
        check("mask_meip_off", 32'(csr_meip_o),    32'd0);
        check("mask_pend_off", 32'(irq_pending_o), 32'd0);
        mie_meie_i = 1'b1;
        tick(1);
        check("mask_meip_on", 32'(csr_meip_o),    32'd1);
        check("mask_pend_on", 32'(irq_pending_o), 32'd1);

        // Ack for a level source has no effect
        ack(C_EXT);
        tick(1);
        check("lvl_ack_meip", 32'(csr_meip_o), 32'd1);
        irq_external_i = 1'b0;
        mie_meie_i     = 1'b0;

        // Single-cycle pulse on edge-mode fast line 3 is latched
        mie_mfie_i    = 15'h7FFF;
        irq_fast_i[3] = 1'b1;
        tick(1);
        irq_fast_i[3] = 1'b0;
        tick(S + 1);
        check("edge_mfip", 32'(csr_mfip_o),    32'h0008);
        check("edge_id",   32'(irq_fast_id_o), 32'd3);
        tick(5);
        check("edge_mfip_hold", 32'(csr_mfip_o),    32'h0008);
        check("edge_id_hold",   32'(irq_fast_id_o), 32'd3);
        ack(C_F4);
        tick(2);
        check("edge_wrong_ack", 32'(csr_mfip_o), 32'h0008);
        ack(C_F3);
        check("edge_ack_lat", 32'(csr_mfip_o), 32'h0008);
        tick(1);
        check("edge_ack_mfip", 32'(csr_mfip_o),    32'h0000);
        check("edge_ack_id",   32'(irq_fast_id_o), 32'd0);

        // NMI: second synced edge coincides with the ack, set must win
        irq_nm_i = 1'b1;
        tick(S + 2);
        check("nmi_first", 32'(irq_nm_o), 32'd1);
        irq_nm_i = 1'b0;
        tick(S + 1);
        irq_nm_i = 1'b1;
        tick(S);
        ack(C_NM);
        tick(1);
        check("nmi_set_wins", 32'(irq_nm_o), 32'd1);
        tick(2);
        check("nmi_hold", 32'(irq_nm_o), 32'd1);
        ack(C_F3);
        tick(1);
        check("nmi_wrong_ack", 32'(irq_nm_o), 32'd1);
        ack(C_NM);
        tick(1);
        check("nmi_cleared", 32'(irq_nm_o), 32'd0);

        // Mid-operation reset discards latches and in-flight syncs
        irq_nm_i = 1'b0;
        tick(S + 1);
        irq_nm_i = 1'b1;
        tick(S + 2);
        check("mid_nm_set", 32'(irq_nm_o), 32'd1);
        irq_fast_i[3] = 1'b1;
        tick(1);
        irq_fast_i[3] = 1'b0;
        irq_nm_i      = 1'b0;
        rst_ni        = 1'b0;
        tick(1);
        check("mid_rst_nm",   32'(irq_nm_o),      32'd0);
        check("mid_rst_mfip", 32'(csr_mfip_o),    32'd0);
        check("mid_rst_pend", 32'(irq_pending_o), 32'd0);
        rst_ni = 1'b1;
        tick(S + 3);
        check("mid_post_nm",   32'(irq_nm_o),   32'd0);
        check("mid_post_mfip", 32'(csr_mfip_o), 32'd0);

        // Ack counter
`ifdef IBEX_IRQ_ACK_CNT_EN
        check("cnt_after_rst", 32'(irq_ack_cnt_o), 32'd0);
        irq_ack_i = 1'b1;
        tick(5);
        irq_ack_i = 1'b0;
        tick(1);
        check("cnt_five", 32'(irq_ack_cnt_o), 32'd5);
        irq_ack_i = 1'b1;
        tick(70000);
        irq_ack_i = 1'b0;
        tick(1);
        check("cnt_sat", 32'(irq_ack_cnt_o), 32'h0000FFFF);
        rst_ni = 1'b0;
        tick(1);
        check("cnt_rst", 32'(irq_ack_cnt_o), 32'd0);
        rst_ni = 1'b1;
`else
        irq_ack_i = 1'b1;
        tick(5);
        irq_ack_i = 1'b0;
        tick(1);
        check("cnt_tied", 32'(irq_ack_cnt_o), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ibex_irq_arbiter.md
Name: ibex_irq_arbiter

Overview:
- Interrupt source side of the controller's irq interface.
- Synchronises raw platform interrupt lines and applies per-source enables.
- Latches edge-triggered fast interrupts and the NMI, and drives irq_pending, msip/mtip/meip, mfip[14:0] and irq_nm into the controller.
- Consumes the controller's "interrupt taken" indication (csr_save_cause plus exc_cause) to clear latched sources.

Parameters:
- SYNC_STAGES, 2, flop stages per raw input line (legal 2..3).
- FAST_EDGE_MASK, 15'h0000, bit i=1 makes irq_fast[i] rising-edge latched; 0 makes it level-sensitive.

Ports:
- CK  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- irq_software_i  in  1  raw machine software irq, level
- irq_timer_i  in  1  raw machine timer irq, level
- irq_external_i  in  1  raw machine external irq, level
- irq_fast_i  in  15  raw fast irqs
- irq_nm_i  in  1  raw NMI, rising-edge latched
- mie_msie_i  in  1  software irq enable
- mie_mtie_i  in  1  timer irq enable
- mie_meie_i  in  1  external irq enable
- mie_mfie_i  in  15  fast irq enables
- irq_ack_i  in  1  controller took an interrupt this cycle (csr_save_cause_o in IRQ_TAKEN)
- irq_ack_cause_i  in  6  exc_cause_o at the time of the ack
- csr_msip_o  out  1  masked software pending
- csr_mtip_o  out  1  masked timer pending
- csr_meip_o  out  1  masked external pending
- csr_mfip_o  out  15  masked fast pending
- irq_pending_o  out  1  OR of all four masked pending outputs
- irq_nm_o  out  1  latched NMI
- irq_fast_id_o  out  4  highest pending fast id (14 highest), 0 if none

Behaviour:
- Reset:
  - Every sync flop, every latch and every output is 0 on the first CK edge with rst_ni=0.
  - Reset asserted mid-operation discards all latched edges and in-flight synchroniser contents.
- Synchronisation:
  - Each of the 19 raw lines passes through SYNC_STAGES flops; sN denotes the final stage.
  - A one-cycle-delayed copy sN_d is kept for edge detection.
  - sN_d resets to 0, so a line held high through reset produces one edge after reset release.
- Level sources (sw, timer, external, fast lines with mask bit 0):
  - raw_pend = sN. No latch.
  - Ack has no effect; the source must deassert itself.
- Edge sources (fast lines with mask bit 1, and the NMI):
  - A latch sets when sN & ~sN_d.
  - Fast line i clears when irq_ack_i and irq_ack_cause_i == {2'b11, i[3:0]}.
  - NMI clears when irq_ack_i and irq_ack_cause_i == EXC_CAUSE_IRQ_NM.
  - A new rising edge in the same cycle as a matching ack leaves the latch set (set wins).
  - An ack whose cause does not match leaves all latches unchanged.
  - An ack for a level source is ignored.
- Outputs are registered:
  - csr_*ip_o = raw_pend & enable, registered.
  - irq_pending_o is registered from the same combinational OR, so it is always consistent with the *ip outputs in the same cycle.
  - irq_nm_o = NMI latch. NMI is not masked.
  - irq_fast_id_o is registered: priority encode of masked fast pending, bit 14 highest.
- Latency:
  - Raw level rise at edge k (enabled) → output high after edge k+SYNC_STAGES+1.
  - Edge sources (fast edge-mode lines and NMI) rise one edge later than level sources (edge k+SYNC_STAGES+2): the edge-detect latch adds one cycle.
  - Enable change → output follows after 1 edge.
  - Ack → latch clear visible on output after 1 edge.
  - The controller therefore sees the pending bit drop one cycle after IRQ_TAKEN. This matches its IRQ_TAKEN→DECODE single-cycle visit.
- State per edge source:
  - IDLE (latch 0) → PEND on detected edge.
  - PEND → IDLE on matching ack without simultaneous edge.
  - No other states.
- Width rules: cause compare is exact 6-bit equality. irq_fast_id_o is a 4-bit unsigned value.

Optional Feature:
- Macro IBEX_IRQ_ACK_CNT_EN.
- When defined:
  - Adds output irq_ack_cnt_o[15:0]: a saturating count of cycles with irq_ack_i=1, holding at 16'hFFFF.
  - Counter is cleared by reset.
- When undefined:
  - Port still present, tied 16'h0000.
  - No counter flops.

Decomposition:
- Cause constants (EXC_CAUSE_IRQ_NM, EXC_CAUSE_IRQ_SOFTWARE_M, EXC_CAUSE_IRQ_TIMER_M, EXC_CAUSE_IRQ_EXTERNAL_M) stay in ibex_pkg.
- Fast cause encoding {2'b11, id} is added to ibex_pkg as a function.
- One sub-module, ibex_irq_sync: parameterised SYNC_STAGES-deep single-bit synchroniser with synchronous active-low reset, instantiated 19 times.

Test Plan:
- Reset: rst_ni=0 for 3 cycles with all raw irqs =1 → all outputs 0 during reset. After release, with all enables set:
  - csr_meip_o=1 and irq_pending_o=1 at edge SYNC_STAGES+1 after release.
  - irq_nm_o=1 one edge later (edge SYNC_STAGES+2), once the edge latch has set.
- Level mask: irq_external_i=1, mie_meie_i=0 → csr_meip_o=0, irq_pending_o=0. Set mie_meie_i=1 → both 1 one edge later.
- Edge fast: FAST_EDGE_MASK=15'h0008, pulse irq_fast_i[3] for 1 cycle → csr_mfip_o=15'h0008 and irq_fast_id_o=3 persist. Ack with cause 6'h33 → cleared next edge. Ack with cause 6'h34 → no change.
- Priority: fast[14] and fast[2] both pending and enabled → irq_fast_id_o=14. Drop 14 → irq_fast_id_o=2.
- NMI: rising edge on irq_nm_i, then matching ack in the same cycle as a second synced rising edge → irq_nm_o stays 1. A lone ack with EXC_CAUSE_IRQ_NM afterwards → 0.
- With IBEX_IRQ_ACK_CNT_EN defined:
  - 5 acks → irq_ack_cnt_o=5.
  - Force 70000 acks → irq_ack_cnt_o=16'hFFFF.
  - Reset → 0.
